// File: rtl/rob_module.sv
// Reorder buffer between rename and the reservation stations: allocates entries, resolves
// pending operands, captures FU results and commits in order. Optional same-cycle FU bypass: ROB_FU_BYPASS_EN.
module rob_module #(
  parameter int ROB_IDX_W = 3,
  parameter int DATA_W    = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_rf_done,
  input  logic [REG_IDX_W-1:0] in_rf_dst,
  input  logic                 in_rf_set_nzcv,
  input  logic                 in_rf_src1_valid,
  input  logic                 in_rf_src2_valid,
  input  logic                 in_rf_nzcv_valid,
  input  logic [DATA_W-1:0]    in_rf_src1_value,
  input  logic [DATA_W-1:0]    in_rf_src2_value,
  input  logic [3:0]           in_rf_nzcv,
  input  logic [ROB_IDX_W-1:0] in_rf_src1_rob_index,
  input  logic [ROB_IDX_W-1:0] in_rf_src2_rob_index,
  input  logic [ROB_IDX_W-1:0] in_rf_nzcv_rob_index,
  input  logic                 in_fu_done,
  input  logic [ROB_IDX_W-1:0] in_fu_rob_index,
  input  logic [DATA_W-1:0]    in_fu_value,
  input  logic [3:0]           in_fu_nzcv,
  input  logic                 in_flush,
  output logic [ROB_IDX_W-1:0] out_next_rob_index,
  output logic                 out_full,
  output logic                 out_err,
  output logic                 out_rs_done,
  output logic [ROB_IDX_W-1:0] out_rs_rob_index,
  output logic                 out_rs_src1_valid,
  output logic [DATA_W-1:0]    out_rs_src1_value,
  output logic [ROB_IDX_W-1:0] out_rs_src1_rob_index,
  output logic                 out_rs_src2_valid,
  output logic [DATA_W-1:0]    out_rs_src2_value,
  output logic [ROB_IDX_W-1:0] out_rs_src2_rob_index,
  output logic                 out_rs_nzcv_valid,
  output logic [3:0]           out_rs_nzcv,
  output logic [ROB_IDX_W-1:0] out_rs_nzcv_rob_index,
  output logic                 out_reg_should_commit,
  output logic [DATA_W-1:0]    out_reg_commit_value,
  output logic [REG_IDX_W-1:0] out_reg_index,
  output logic [ROB_IDX_W-1:0] out_reg_commit_rob_index,
  output logic                 out_reg_set_nzcv,
  output logic [3:0]           out_reg_nzcv
);

  localparam int DEPTH = 1 << ROB_IDX_W;
  localparam logic [ROB_IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [ROB_IDX_W:0]   CNT_ONE  = 1;
  localparam logic [ROB_IDX_W:0]   CNT_FULL = {1'b1, {ROB_IDX_W{1'b0}}};

  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     done_q;
  logic [REG_IDX_W-1:0] dst_q      [DEPTH];
  logic                 set_nzcv_q [DEPTH];
  logic [DATA_W-1:0]    value_q    [DEPTH];
  logic [3:0]           nzcv_q     [DEPTH];

  logic [ROB_IDX_W-1:0] head_q, tail_q;
  logic [ROB_IDX_W:0]   count_q;

  logic dispatch, commit, wb_en, full;

  logic              s1_valid, s2_valid, nf_valid;
  logic [DATA_W-1:0] s1_value, s2_value;
  logic [3:0]        nf_value;

  // Handshake: in_rf_done is a valid with no ready; the source must hold off while
  // out_full is high, and a dispatch offered while full is dropped and flagged on out_err.
  // All other *_done inputs/outputs are single-cycle valid strobes with no back-pressure.
  assign full     = (count_q == CNT_FULL);
  assign dispatch = in_rf_done && !full && !in_flush;
  assign wb_en    = in_fu_done && !in_flush && busy_q[in_fu_rob_index];
  assign commit   = !in_flush && (count_q != '0) && busy_q[head_q] && done_q[head_q];

  assign out_next_rob_index = tail_q;
  assign out_full           = full;

`ifdef ROB_FU_BYPASS_EN
  function automatic logic fu_hit(input logic [ROB_IDX_W-1:0] tag);
    return wb_en && (in_fu_rob_index == tag);
  endfunction
`endif

  always_comb begin
    s1_valid = 1'b0;
    s1_value = '0;
    if (in_rf_src1_valid) begin
      s1_valid = 1'b1;
      s1_value = in_rf_src1_value;
    end else if (busy_q[in_rf_src1_rob_index] && done_q[in_rf_src1_rob_index]) begin
      s1_valid = 1'b1;
      s1_value = value_q[in_rf_src1_rob_index];
    end
`ifdef ROB_FU_BYPASS_EN
    else if (fu_hit(in_rf_src1_rob_index)) begin
      s1_valid = 1'b1;
      s1_value = in_fu_value;
    end
`endif

    s2_valid = 1'b0;
    s2_value = '0;
    if (in_rf_src2_valid) begin
      s2_valid = 1'b1;
      s2_value = in_rf_src2_value;
    end else if (busy_q[in_rf_src2_rob_index] && done_q[in_rf_src2_rob_index]) begin
      s2_valid = 1'b1;
      s2_value = value_q[in_rf_src2_rob_index];
    end
`ifdef ROB_FU_BYPASS_EN
    else if (fu_hit(in_rf_src2_rob_index)) begin
      s2_valid = 1'b1;
      s2_value = in_fu_value;
    end
`endif

    nf_valid = 1'b0;
    nf_value = '0;
    if (in_rf_nzcv_valid) begin
      nf_valid = 1'b1;
      nf_value = in_rf_nzcv;
    end else if (busy_q[in_rf_nzcv_rob_index] && done_q[in_rf_nzcv_rob_index]) begin
      nf_valid = 1'b1;
      nf_value = nzcv_q[in_rf_nzcv_rob_index];
    end
`ifdef ROB_FU_BYPASS_EN
    else if (fu_hit(in_rf_nzcv_rob_index)) begin
      nf_valid = 1'b1;
      nf_value = in_fu_nzcv;
    end
`endif
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      head_q                   <= '0;
      tail_q                   <= '0;
      count_q                  <= '0;
      busy_q                   <= '0;
      done_q                   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]      <= '0;
        set_nzcv_q[i] <= 1'b0;
        value_q[i]    <= '0;
        nzcv_q[i]     <= '0;
      end
      out_err                  <= 1'b0;
      out_rs_done              <= 1'b0;
      out_rs_rob_index         <= '0;
      out_rs_src1_valid        <= 1'b0;
      out_rs_src1_value        <= '0;
      out_rs_src1_rob_index    <= '0;
      out_rs_src2_valid        <= 1'b0;
      out_rs_src2_value        <= '0;
      out_rs_src2_rob_index    <= '0;
      out_rs_nzcv_valid        <= 1'b0;
      out_rs_nzcv              <= '0;
      out_rs_nzcv_rob_index    <= '0;
      out_reg_should_commit    <= 1'b0;
      out_reg_commit_value     <= '0;
      out_reg_index            <= '0;
      out_reg_commit_rob_index <= '0;
      out_reg_set_nzcv         <= 1'b0;
      out_reg_nzcv             <= '0;
    end else begin
      out_rs_done           <= dispatch;
      out_reg_should_commit <= commit;
      if (in_rf_done && full && !in_flush) out_err <= 1'b1;

      if (in_flush) begin
        busy_q  <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        // The tail entry is never busy while dispatching, so a writeback cannot collide with it.
        if (wb_en) begin
          done_q[in_fu_rob_index]  <= 1'b1;
          value_q[in_fu_rob_index] <= in_fu_value;
          nzcv_q[in_fu_rob_index]  <= in_fu_nzcv;
        end

        if (dispatch) begin
          busy_q[tail_q]        <= 1'b1;
          done_q[tail_q]        <= 1'b0;
          dst_q[tail_q]         <= in_rf_dst;
          set_nzcv_q[tail_q]    <= in_rf_set_nzcv;
          tail_q                <= tail_q + IDX_ONE;
          out_rs_rob_index      <= tail_q;
          out_rs_src1_valid     <= s1_valid;
          out_rs_src1_value     <= s1_value;
          out_rs_src1_rob_index <= in_rf_src1_rob_index;
          out_rs_src2_valid     <= s2_valid;
          out_rs_src2_value     <= s2_value;
          out_rs_src2_rob_index <= in_rf_src2_rob_index;
          out_rs_nzcv_valid     <= nf_valid;
          out_rs_nzcv           <= nf_value;
          out_rs_nzcv_rob_index <= in_rf_nzcv_rob_index;
        end

        if (commit) begin
          busy_q[head_q]           <= 1'b0;
          head_q                   <= head_q + IDX_ONE;
          out_reg_commit_value     <= value_q[head_q];
          out_reg_index            <= dst_q[head_q];
          out_reg_commit_rob_index <= head_q;
          out_reg_set_nzcv         <= set_nzcv_q[head_q];
          out_reg_nzcv             <= nzcv_q[head_q];
        end

        case ({dispatch, commit})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_module.sv
// Directed bench for rob_module: fill/overflow, in-order commit, operand resolution,
// same-cycle bypass (follows ROB_FU_BYPASS_EN), flush and asynchronous reset.
module tb_rob_module;

  localparam int ROB_IDX_W = 3;
  localparam int DATA_W    = 64;
  localparam int REG_IDX_W = 5;
  localparam int SB_W      = REG_IDX_W + DATA_W;

  logic                 in_clk;
  logic                 in_rst_n;
  logic                 in_rf_done;
  logic [REG_IDX_W-1:0] in_rf_dst;
  logic                 in_rf_set_nzcv;
  logic                 in_rf_src1_valid, in_rf_src2_valid, in_rf_nzcv_valid;
  logic [DATA_W-1:0]    in_rf_src1_value, in_rf_src2_value;
  logic [3:0]           in_rf_nzcv;
  logic [ROB_IDX_W-1:0] in_rf_src1_rob_index, in_rf_src2_rob_index, in_rf_nzcv_rob_index;
  logic                 in_fu_done;
  logic [ROB_IDX_W-1:0] in_fu_rob_index;
  logic [DATA_W-1:0]    in_fu_value;
  logic [3:0]           in_fu_nzcv;
  logic                 in_flush;
  logic [ROB_IDX_W-1:0] out_next_rob_index;
  logic                 out_full, out_err, out_rs_done;
  logic [ROB_IDX_W-1:0] out_rs_rob_index;
  logic                 out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid;
  logic [DATA_W-1:0]    out_rs_src1_value, out_rs_src2_value;
  logic [3:0]           out_rs_nzcv;
  logic [ROB_IDX_W-1:0] out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index;
  logic                 out_reg_should_commit;
  logic [DATA_W-1:0]    out_reg_commit_value;
  logic [REG_IDX_W-1:0] out_reg_index;
  logic [ROB_IDX_W-1:0] out_reg_commit_rob_index;
  logic                 out_reg_set_nzcv;
  logic [3:0]           out_reg_nzcv;

  int n_checks = 0;
  int n_errors = 0;
  logic [SB_W-1:0] exp_q[$];

  rob_module #(.ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_rf_done(in_rf_done), .in_rf_dst(in_rf_dst), .in_rf_set_nzcv(in_rf_set_nzcv),
    .in_rf_src1_valid(in_rf_src1_valid), .in_rf_src2_valid(in_rf_src2_valid),
    .in_rf_nzcv_valid(in_rf_nzcv_valid),
    .in_rf_src1_value(in_rf_src1_value), .in_rf_src2_value(in_rf_src2_value),
    .in_rf_nzcv(in_rf_nzcv),
    .in_rf_src1_rob_index(in_rf_src1_rob_index), .in_rf_src2_rob_index(in_rf_src2_rob_index),
    .in_rf_nzcv_rob_index(in_rf_nzcv_rob_index),
    .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index), .in_fu_value(in_fu_value),
    .in_fu_nzcv(in_fu_nzcv), .in_flush(in_flush),
    .out_next_rob_index(out_next_rob_index), .out_full(out_full), .out_err(out_err),
    .out_rs_done(out_rs_done), .out_rs_rob_index(out_rs_rob_index),
    .out_rs_src1_valid(out_rs_src1_valid), .out_rs_src1_value(out_rs_src1_value),
    .out_rs_src1_rob_index(out_rs_src1_rob_index),
    .out_rs_src2_valid(out_rs_src2_valid), .out_rs_src2_value(out_rs_src2_value),
    .out_rs_src2_rob_index(out_rs_src2_rob_index),
    .out_rs_nzcv_valid(out_rs_nzcv_valid), .out_rs_nzcv(out_rs_nzcv),
    .out_rs_nzcv_rob_index(out_rs_nzcv_rob_index),
    .out_reg_should_commit(out_reg_should_commit), .out_reg_commit_value(out_reg_commit_value),
    .out_reg_index(out_reg_index), .out_reg_commit_rob_index(out_reg_commit_rob_index),
    .out_reg_set_nzcv(out_reg_set_nzcv), .out_reg_nzcv(out_reg_nzcv)
  );

  // Clock / reset
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    in_rf_done = 1'b0; in_rf_dst = '0; in_rf_set_nzcv = 1'b0;
    in_rf_src1_valid = 1'b0; in_rf_src2_valid = 1'b0; in_rf_nzcv_valid = 1'b0;
    in_rf_src1_value = '0; in_rf_src2_value = '0; in_rf_nzcv = '0;
    in_rf_src1_rob_index = '0; in_rf_src2_rob_index = '0; in_rf_nzcv_rob_index = '0;
    in_fu_done = 1'b0; in_fu_rob_index = '0; in_fu_value = '0; in_fu_nzcv = '0;
    in_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
    in_rf_done = 1'b0;
    in_fu_done = 1'b0;
    in_flush   = 1'b0;
  endtask

  task automatic set_dispatch(input logic [REG_IDX_W-1:0] dst, input logic set_nzcv,
                              input logic s1_valid, input logic [ROB_IDX_W-1:0] s1_tag,
                              input logic nf_valid, input logic [ROB_IDX_W-1:0] nf_tag);
    in_rf_done           = 1'b1;
    in_rf_dst            = dst;
    in_rf_set_nzcv       = set_nzcv;
    in_rf_src1_valid     = s1_valid;
    in_rf_src1_value     = 64'h1000;
    in_rf_src1_rob_index = s1_tag;
    in_rf_src2_valid     = 1'b1;
    in_rf_src2_value     = 64'h2000;
    in_rf_src2_rob_index = '0;
    in_rf_nzcv_valid     = nf_valid;
    in_rf_nzcv           = 4'h3;
    in_rf_nzcv_rob_index = nf_tag;
  endtask

  task automatic set_wb(input logic [ROB_IDX_W-1:0] idx, input logic [DATA_W-1:0] val,
                        input logic [3:0] nzcv);
    in_fu_done      = 1'b1;
    in_fu_rob_index = idx;
    in_fu_value     = val;
    in_fu_nzcv      = nzcv;
  endtask

  // Scoreboard: commits must arrive in program order with {dst, value} from exp_q
  always @(negedge in_clk) begin
    if (in_rst_n && out_reg_should_commit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 96'(out_reg_commit_rob_index) + 96'd1, 96'd0);
      end else begin
        check("commit_data", 96'({out_reg_index, out_reg_commit_value}), 96'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    idle_inputs();
    in_rst_n = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    check("rst_next_idx", out_next_rob_index, 0);
    check("rst_full", out_full, 0);
    check("rst_err", out_err, 0);
    check("rst_rs_done", out_rs_done, 0);
    check("rst_commit", out_reg_should_commit, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    tick();

    // Fill all 8 entries, dst = 10 + i, set_nzcv = i[0]
    for (int i = 0; i < 8; i++) begin
      set_dispatch(5'(10 + i), i[0], 1'b1, 3'd0, 1'b1, 3'd0);
      tick();
      if (i == 0) begin
        check("first_rs_done", out_rs_done, 1);
        check("first_rs_idx", out_rs_rob_index, 0);
        check("first_src1_valid", out_rs_src1_valid, 1);
        check("first_src1_value", out_rs_src1_value, 64'h1000);
        check("first_next_idx", out_next_rob_index, 1);
        check("first_full", out_full, 0);
      end
    end
    check("fill_full", out_full, 1);
    check("fill_next_idx", out_next_rob_index, 0);
    check("fill_err", out_err, 0);
    set_dispatch(5'd30, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    tick();
    check("ovf_err", out_err, 1);
    check("ovf_next_idx", out_next_rob_index, 0);
    check("ovf_rs_done", out_rs_done, 0);
    check("ovf_full", out_full, 1);

    // Out-of-order writeback 2, 0, 1 -> commits 0, 1, 2 back to back
    exp_q.push_back({5'd10, 64'h00});
    exp_q.push_back({5'd11, 64'h11});
    exp_q.push_back({5'd12, 64'h22});
    set_wb(3'd2, 64'h22, 4'h0);
    tick();
    check("ooo_no_commit_a", out_reg_should_commit, 0);
    set_wb(3'd0, 64'h00, 4'h0);
    tick();
    check("ooo_no_commit_b", out_reg_should_commit, 0);
    set_wb(3'd1, 64'h11, 4'h0);
    tick();
    check("ooo_commit0", out_reg_should_commit, 1);
    check("ooo_commit0_idx", out_reg_commit_rob_index, 0);
    check("ooo_full_drop", out_full, 0);
    tick();
    check("ooo_commit1", out_reg_should_commit, 1);
    check("ooo_commit1_idx", out_reg_commit_rob_index, 1);
    check("ooo_commit1_reg", out_reg_index, 11);
    tick();
    check("ooo_commit2", out_reg_should_commit, 1);
    check("ooo_commit2_idx", out_reg_commit_rob_index, 2);
    check("ooo_err_sticky", out_err, 1);

    // Entry 3 done with 7 / nzcv A; dispatch resolves src1 and nzcv from it
    set_wb(3'd3, 64'h7, 4'hA);
    tick();
    check("res_no_commit", out_reg_should_commit, 0);
    exp_q.push_back({5'd13, 64'h7});
    set_dispatch(5'd20, 1'b0, 1'b0, 3'd3, 1'b0, 3'd3);
    tick();
    check("res_rs_done", out_rs_done, 1);
    check("res_rs_idx", out_rs_rob_index, 0);
    check("res_src1_valid", out_rs_src1_valid, 1);
    check("res_src1_value", out_rs_src1_value, 64'h7);
    check("res_nzcv_valid", out_rs_nzcv_valid, 1);
    check("res_nzcv", out_rs_nzcv, 4'hA);
    check("res_commit3", out_reg_should_commit, 1);
    check("res_commit3_idx", out_reg_commit_rob_index, 3);
    check("res_commit3_setf", out_reg_set_nzcv, 1);
    check("res_commit3_nzcv", out_reg_nzcv, 4'hA);

    // Entry 5 busy but not done -> operand stays pending with its tag
    set_dispatch(5'd21, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0);
    tick();
    check("pend_rs_idx", out_rs_rob_index, 1);
    check("pend_src1_valid", out_rs_src1_valid, 0);
    check("pend_src1_tag", out_rs_src1_rob_index, 5);

    // Same-cycle writeback to tag 4 and a dispatch that needs it
    set_wb(3'd4, 64'h5A, 4'h5);
    set_dispatch(5'd22, 1'b0, 1'b0, 3'd4, 1'b1, 3'd0);
    tick();
    check("byp_rs_idx", out_rs_rob_index, 2);
`ifdef ROB_FU_BYPASS_EN
    check("byp_src1_valid", out_rs_src1_valid, 1);
    check("byp_src1_value", out_rs_src1_value, 64'h5A);
`else
    check("byp_src1_valid", out_rs_src1_valid, 0);
    check("byp_src1_tag", out_rs_src1_rob_index, 4);
`endif
    exp_q.push_back({5'd14, 64'h5A});
    tick();
    check("byp_commit4", out_reg_should_commit, 1);
    check("byp_commit4_idx", out_reg_commit_rob_index, 4);

    exp_q.push_back({5'd15, 64'h55});
    set_wb(3'd5, 64'h55, 4'h0);
    tick();
    tick();
    check("pre_flush_commit5", out_reg_commit_rob_index, 5);
    check("pre_flush_next_idx", out_next_rob_index, 3);

    // Flush with entries 6,7,0,1,2 busy, plus a dispatch and a head writeback
    set_dispatch(5'd23, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    set_wb(3'd6, 64'h66, 4'h0);
    in_flush = 1'b1;
    tick();
    check("flush_rs_done", out_rs_done, 0);
    check("flush_commit", out_reg_should_commit, 0);
    check("flush_next_idx", out_next_rob_index, 0);
    check("flush_full", out_full, 0);
    check("flush_err_kept", out_err, 1);
    set_wb(3'd1, 64'hBB, 4'h0);
    tick();
    check("post_flush_commit", out_reg_should_commit, 0);
    set_dispatch(5'd24, 1'b1, 1'b0, 3'd1, 1'b1, 3'd0);
    tick();
    check("post_flush_rs_idx", out_rs_rob_index, 0);
    check("post_flush_src1_valid", out_rs_src1_valid, 0);
    check("post_flush_src1_tag", out_rs_src1_rob_index, 1);
    check("post_flush_next_idx", out_next_rob_index, 1);

    // Build three busy entries with a commit in flight, then reset asynchronously
    set_dispatch(5'd25, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    tick();
    exp_q.push_back({5'd24, 64'h77});
    set_dispatch(5'd26, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    set_wb(3'd0, 64'h77, 4'hC);
    tick();
    set_dispatch(5'd27, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    tick();
    check("pre_rst_commit", out_reg_should_commit, 1);
    check("pre_rst_rs_done", out_rs_done, 1);
    check("pre_rst_next_idx", out_next_rob_index, 4);
    @(negedge in_clk);
    #1;
    in_rst_n = 1'b0;
    #1;
    check("arst_rs_done", out_rs_done, 0);
    check("arst_commit", out_reg_should_commit, 0);
    check("arst_commit_value", out_reg_commit_value, 0);
    check("arst_src1_value", out_rs_src1_value, 0);
    check("arst_next_idx", out_next_rob_index, 0);
    check("arst_err", out_err, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    tick();
    check("rel_next_idx", out_next_rob_index, 0);
    check("rel_full", out_full, 0);
    set_dispatch(5'd28, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    tick();
    check("rel_rs_idx", out_rs_rob_index, 0);
    check("rel_next_idx_after", out_next_rob_index, 1);
    tick();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
